// File: rtl/dm_pkg.sv
// ============================================================================
// Module : dm_pkg
// Brief  : Shared FSM encoding and LATENCY bounds for the data-memory responder
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  // Wide enough to hold LATENCY_MAX-1.
  localparam int CNT_W       = 4;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_ram.sv
// ============================================================================
// Module : dm_ram
// Brief  : Single-port word RAM, byte-enabled synchronous write, registered read
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_ram
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  // Array contents are intentionally left out of reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only moves on a read, so it holds across writes and errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// Module : dm_responder
// Brief  : Fixed-latency CPU data-memory responder with alignment/range check
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int AW = addr_bits(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dm_responder: LATENCY out of range 1..15");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             err_q;
  logic             addr_err;
  logic             accept;
  logic             access;

  assign addr_err = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
  assign accept   = (state == ST_IDLE) && req;
  assign access   = (state == ST_WAIT) && (cnt == '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (addr_err) begin
            state_nx = ST_RESP;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx = ST_RESP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr[AW+1:2];
        wdata_q <= wdata;
        be_q    <= be;
        err_q   <= addr_err;
      end
    end
  end

  assign ack  = (state == ST_RESP);
  assign err  = ack && err_q;
  assign busy = (state != ST_IDLE);

  // Storage is only touched on the final WAIT edge, so a reset in WAIT drops it.
  dm_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (access),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module : tb_dm_responder
// Brief  : Scoreboard bench for dm_responder with a word-array reference model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dm_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, err, busy, ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [31:0] rdata, rdata_a, rdata_b;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy));

  dm_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_n), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a));

  dm_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst_n), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b));

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          e0;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: word array plus "last read value" register.
  function automatic void push_exp(input logic w, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mem_m[a[31:2]][8*i +: 8] = d[8*i +: 8];
      end else begin
        last_rd = mem_m[a[31:2]];
      end
    end
    e.rdata = last_rd;
    e.lat   = e.err ? 1 : LAT + 1;
    e.e0    = cyc + 1;
    sbq.push_back(e);
  endfunction

  // Monitor: every ack pops one expectation.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      chk("ack_width", {31'b0, prev_ack}, 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_err", {31'b0, err}, {31'b0, e.err});
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_latency", cyc - e.e0 + 1, e.lat);
      end
    end
    prev_ack = ack;
  end

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      chk("issue_timeout", 32'd1, 32'd0);
      return;
    end
    we = w; addr = a; wdata = d; be = b; req = 1'b1;
    push_exp(w, a, d, b);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy || sbq.size() != 0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic lat_test(input int lat, input int sel);
    for (int op = 0; op < 2; op++) begin
      int   n;
      logic got;
      n = 0;
      got = 1'b0;
      @(negedge clk);
      we = (op == 0); addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
      if (sel == 0) req_a = 1'b1; else req_b = 1'b1;
      while (!got && n < 40) begin
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        n++;
        got = (sel == 0) ? ack_a : ack_b;
      end
      chk($sformatf("lat%0d_ack_latency", lat), n, lat + 1);
      chk($sformatf("lat%0d_err", lat), {31'b0, (sel == 0) ? err_a : err_b}, 32'd0);
      if (op == 1)
        chk($sformatf("lat%0d_rdata", lat), (sel == 0) ? rdata_a : rdata_b, 32'hDEADBEEF);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    lat_test(1, 0);
    lat_test(15, 1);

    // Give the model a defined image of storage.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full-word write then read
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    wait_idle();
    chk("rw_0x10_rdata", rdata, 32'hDEADBEEF);

    // Partial byte-enable merge
    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    wait_idle();
    chk("be_merge_rdata", rdata, 32'h11BB33DD);

    // Misaligned and out-of-range errors; be=0000 write still acks
    issue(1'b0, 32'h12, 32'h0, 4'hF);
    issue(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    issue(1'b0, 32'h20, 32'h0, 4'hF);
    wait_idle();
    chk("err_hold_rdata", rdata, 32'h11BB33DD);

    // req held high for 10 cycles
    we = 1'b0; addr = 32'h10; be = 4'hF; req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_busy", {31'b0, busy}, {31'b0, (i % (LAT + 2)) != 0});
      if (!busy) push_exp(1'b0, 32'h10, 32'h0, 4'hF);
    end
    @(negedge clk);
    req = 1'b0;
    wait_idle();

    // Reset during WAIT drops the write
    we = 1'b1; addr = 32'h40; wdata = ~mem_m[16]; be = 4'hF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 32'h40, 32'h0, 4'hF);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {$urandom_range(0, DEPTH - 1), 2'b00};
      else if (r == 7) a = {$urandom_range(0, DEPTH - 1), 2'(r % 3 + 1)};
      else if (r == 8) a = {$urandom_range(DEPTH, DEPTH + 50), 2'b00};
      else             a = $urandom | 32'h8000_0000;
      d = $urandom;
      issue(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  CPU data-memory request.
REQ-007 SHALL have port we  input  1  request is write (1) or read (0).
REQ-008 SHALL have port addr  input  32  byte address from the CPU ALU output.
REQ-009 SHALL have port wdata  input  32  write data from the CPU.
REQ-010 SHALL have port be  input  4  byte enables; be[i] selects wdata[8i+7:8i].
REQ-011 SHALL have port ack  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata  output  32  registered read data.
REQ-013 SHALL have port err  output  1  error flag, valid only with ack.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL sample req only in IDLE; a rising edge with req=1 is the accept edge E0, latching we, addr, wdata and be.
REQ-017 SHALL flag an error at E0 when addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-018 SHALL, on error, go IDLE->RESP at E0 with no storage access, giving ack=1, err=1 in the cycle after E0.
REQ-019 SHALL, without error, go IDLE->WAIT at E0 and load a down-counter with LATENCY-1.
REQ-020 SHALL decrement the counter each WAIT cycle; the edge where it equals 0 performs the access and moves to RESP.
REQ-021 SHALL, on a write, update only the bytes whose be bit is 1; be=0000 leaves storage unchanged and still acks.
REQ-022 SHALL, on a read, load rdata with the full addressed word on the access edge.
REQ-023 SHALL hold rdata unchanged on writes and on errors.
REQ-024 SHALL assert ack for exactly one cycle, in RESP, with err=0 for successful accesses; RESP->IDLE is unconditional.
REQ-025 SHALL make the successful-access latency exactly LATENCY+1 cycles from E0 to the ack cycle.
REQ-026 SHALL ignore req in WAIT and RESP; a req held high through RESP is accepted at the first edge in IDLE.
REQ-027 SHALL give a read issued after a write's ack the newly written data.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, counter 0, ack=0, err=0, busy=0 and rdata=0.
REQ-029 SHALL, on reset asserted in WAIT, drop the pending access with no storage write.
REQ-030 SHALL not clear storage on reset.

Structure
REQ-031 SHALL define the state encoding and the LATENCY bound in shared package dm_pkg.
REQ-032 SHALL place storage in a sub-module dm_ram: single-port, synchronous byte-enabled write, synchronous read, DEPTH words.

Verification
REQ-033 Bench SHALL cover: write addr=0x10, wdata=0xDEADBEEF, be=1111, then read 0x10 -> ack 3 cycles after each E0, err=0, rdata=0xDEADBEEF.
REQ-034 Bench SHALL cover: word 0x20 holds 0x11223344; write be=0101, wdata=0xAABBCCDD; read 0x20 -> rdata=0x11BB33DD.
REQ-035 Bench SHALL cover: read addr=0x12 and read addr=DEPTH*4 -> ack 1 cycle after E0, err=1, rdata unchanged.
REQ-036 Bench SHALL cover: req held high for 10 cycles -> accepts spaced LATENCY+2 cycles apart, ack pulses 1 cycle wide, busy low only on the accept cycles.
REQ-037 Bench SHALL cover: write to 0x40 issued, rst pulsed low during WAIT -> no ack; a later read of 0x40 returns its prior contents.
REQ-038 Bench SHALL cover: rerun REQ-033 with LATENCY=1 and LATENCY=15 -> ack exactly 2 and 16 cycles after E0.
